// File: rtl/vector_check_pkg.sv
// Shared types and helpers for the exhaustive vector-check sequencer.
package vector_check_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCheck,
        StDone
    } state_t;

    // Index of the final vector in an n-bit exhaustive sweep.
    function automatic int unsigned last_vec(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/vec_counter.sv
// Up-counter for the test vector; clears on request and stops at the last vector.
module vec_counter #(
    parameter int unsigned N = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [N-1:0] q_o,
    output logic         last_o
);
    import vector_check_pkg::*;

    localparam logic [N-1:0] Last = N'(last_vec(N));

    logic [N-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i && (q_q != Last)) begin
            q_d = q_q + N'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign last_o = (q_q == Last);

endmodule

// File: rtl/vector_check_ctrl.sv
// Sweeps all 2^N input vectors, compares DUT against reference after a settle delay,
// and reports mismatch count, first failing vector and pass/fail.
module vector_check_ctrl #(
    parameter int unsigned N      = 3,
    parameter int unsigned W      = 1,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERRW   = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    output logic [N-1:0]    vec_o,
    input  logic [W-1:0]    dut_y_i,
    input  logic [W-1:0]    exp_y_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [ERRW-1:0] errors_o,
    output logic [N-1:0]    first_err_vec_o,
    output logic            err_seen_o
);
    import vector_check_pkg::*;

    localparam int unsigned     CntW    = $clog2(SETTLE + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [ERRW-1:0] errors_q, errors_d;
    logic [N-1:0]    first_q, first_d;
    logic            seen_q, seen_d;
    logic            pass_q, pass_d;
    logic [N-1:0]    vec;
    logic            vec_last, vec_en, start_go, in_check, mismatch;

    assign start_go = start_i && ((state_q == StIdle) || (state_q == StDone));
    assign in_check = (state_q == StCheck);
    assign mismatch = (dut_y_i != exp_y_i);
    assign vec_en   = in_check && !vec_last;

    vec_counter #(
        .N(N)
    ) u_vec_counter (
        .clk_i  (clk_i),
        .rst_i  (reset_i),
        .clr_i  (start_go),
        .en_i   (vec_en),
        .q_o    (vec),
        .last_o (vec_last)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start_i) state_d = StWait;
            StWait:         if (cnt_q == CntLast) state_d = StCheck;
            StCheck:        state_d = vec_last ? StDone : StWait;
            default:        state_d = StIdle;
        endcase
    end

    // Result datapath; pass is resolved with the final compare folded in.
    always_comb begin
        cnt_d    = cnt_q;
        errors_d = errors_q;
        first_d  = first_q;
        seen_d   = seen_q;
        pass_d   = pass_q;
        if (start_go) begin
            cnt_d    = '0;
            errors_d = '0;
            first_d  = '0;
            seen_d   = 1'b0;
            pass_d   = 1'b0;
        end else if (state_q == StWait) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        end else if (in_check) begin
            if (mismatch) begin
                if (errors_q != '1) errors_d = errors_q + ERRW'(1);
                if (!seen_q) begin
                    first_d = vec;
                    seen_d  = 1'b1;
                end
            end
            if (vec_last) pass_d = (errors_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            errors_q <= '0;
            first_q  <= '0;
            seen_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            errors_q <= errors_d;
            first_q  <= first_d;
            seen_q   <= seen_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        busy_o          = (state_q == StWait) || (state_q == StCheck);
        done_o          = (state_q == StDone);
        pass_o          = pass_q;
        errors_o        = errors_q;
        first_err_vec_o = first_q;
        err_seen_o      = seen_q;
        vec_o           = vec;
    end

endmodule

// File: tb/tb_vector_check_ctrl.sv
// Directed bench: instance 0 uses SETTLE=1, instance 1 uses SETTLE=3.
module tb_vector_check_ctrl;

    logic        clk = 1'b0;
    logic [1:0]  start;
    logic [1:0]  rst;
    int          mode [2];
    logic [2:0]  vec [2];
    logic [1:0]  dut_y, exp_y, busy, done, pass, seen;
    logic [31:0] errors [2];
    logic [2:0]  fev [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic ref_f(input logic [2:0] v);
        logic a, b, c;
        {a, b, c} = v;
        return (a & ~b) | (~b & ~c) | (~a & b & c);
    endfunction

    // 0: correct, 1: stuck at 0, 2: inverted only at vector 6
    function automatic logic fault_f(input int m, input logic [2:0] v);
        case (m)
            1:       return 1'b0;
            2:       return (v == 3'd6) ? ~ref_f(v) : ref_f(v);
            default: return ref_f(v);
        endcase
    endfunction

    assign exp_y[0] = ref_f(vec[0]);
    assign exp_y[1] = ref_f(vec[1]);
    assign dut_y[0] = fault_f(mode[0], vec[0]);
    assign dut_y[1] = fault_f(mode[1], vec[1]);

    vector_check_ctrl #(.N(3), .W(1), .SETTLE(1), .ERRW(32)) u_dut0 (
        .clk_i(clk), .reset_i(rst[0]), .start_i(start[0]), .vec_o(vec[0]),
        .dut_y_i(dut_y[0]), .exp_y_i(exp_y[0]), .busy_o(busy[0]), .done_o(done[0]),
        .pass_o(pass[0]), .errors_o(errors[0]), .first_err_vec_o(fev[0]), .err_seen_o(seen[0])
    );

    vector_check_ctrl #(.N(3), .W(1), .SETTLE(3), .ERRW(32)) u_dut1 (
        .clk_i(clk), .reset_i(rst[1]), .start_i(start[1]), .vec_o(vec[1]),
        .dut_y_i(dut_y[1]), .exp_y_i(exp_y[1]), .busy_o(busy[1]), .done_o(done[1]),
        .pass_o(pass[1]), .errors_o(errors[1]), .first_err_vec_o(fev[1]), .err_seen_o(seen[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input int sel, input string tag);
        check({tag, " vec"},    32'(vec[sel]), 0);
        check({tag, " busy"},   32'(busy[sel]), 0);
        check({tag, " done"},   32'(done[sel]), 0);
        check({tag, " pass"},   32'(pass[sel]), 0);
        check({tag, " errors"}, errors[sel], 0);
        check({tag, " fev"},    32'(fev[sel]), 0);
        check({tag, " seen"},   32'(seen[sel]), 0);
    endtask

    // Issues a start, then counts edges after e0 until done; checks vec order per edge.
    task automatic run_sweep(input int sel, input bit hold, input int pulse_at,
                             input string tag, output int edges);
        bit vec_ok = 1'b1;
        int s = (sel == 1) ? 3 : 1;
        int ev;
        @(negedge clk) start[sel] = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " start-edge errors"}, errors[sel], 0);
        check({tag, " start-edge busy"}, 32'(busy[sel]), 1);
        check({tag, " start-edge vec"}, 32'(vec[sel]), 0);
        check({tag, " start-edge done"}, 32'(done[sel]), 0);
        edges = -1;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk) start[sel] = hold || (j == pulse_at);
            @(posedge clk);
            #1;
            ev = j / (s + 1);
            if (ev > 7) ev = 7;
            if (vec[sel] !== 3'(ev)) vec_ok = 1'b0;
            if (done[sel]) begin
                edges = j;
                break;
            end
        end
        @(negedge clk) start[sel] = 1'b0;
        check({tag, " vec order"}, 32'(vec_ok), 1);
    endtask

    task automatic check_result(input int sel, input string tag, input int edges,
                                input int exp_edges, input int exp_err, input int exp_fev,
                                input int exp_seen, input int exp_pass);
        check({tag, " done edge"}, edges, exp_edges);
        check({tag, " errors"},    errors[sel], exp_err);
        check({tag, " fev"},       32'(fev[sel]), exp_fev);
        check({tag, " seen"},      32'(seen[sel]), exp_seen);
        check({tag, " pass"},      32'(pass[sel]), exp_pass);
        check({tag, " busy"},      32'(busy[sel]), 0);
        check({tag, " last vec"},  32'(vec[sel]), 7);
    endtask

    typedef struct {
        int sel;
        int mode;
        int edges;
        int errs;
        int fev;
        int seen;
        int pass;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int edges;
        tbl[0] = '{sel: 0, mode: 0, edges: 16, errs: 0, fev: 0, seen: 0, pass: 1};
        tbl[1] = '{sel: 0, mode: 1, edges: 16, errs: 4, fev: 0, seen: 1, pass: 0};
        tbl[2] = '{sel: 0, mode: 2, edges: 16, errs: 1, fev: 6, seen: 1, pass: 0};
        tbl[3] = '{sel: 1, mode: 1, edges: 32, errs: 4, fev: 0, seen: 1, pass: 0};
        tbl[4] = '{sel: 1, mode: 1, edges: 32, errs: 4, fev: 0, seen: 1, pass: 0};
        tbl[5] = '{sel: 1, mode: 0, edges: 32, errs: 0, fev: 0, seen: 0, pass: 1};

        start = 2'b00;
        rst = 2'b11;
        mode[0] = 0;
        mode[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset(0, "reset0");
        check_reset(1, "reset1");
        @(negedge clk) rst = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("idle stays idle busy", 32'(busy[0]), 0);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            mode[tbl[i].sel] = tbl[i].mode;
            run_sweep(tbl[i].sel, 1'b0, 0, tag, edges);
            check_result(tbl[i].sel, tag, edges, tbl[i].edges, tbl[i].errs, tbl[i].fev,
                         tbl[i].seen, tbl[i].pass);
            repeat (2) @(posedge clk);
            #1;
            check({tag, " done held"}, 32'(done[tbl[i].sel]), 1);
            check({tag, " errors held"}, errors[tbl[i].sel], tbl[i].errs);
        end

        // start held for the whole sweep must not restart it
        mode[0] = 1;
        run_sweep(0, 1'b1, 0, "hold", edges);
        check_result(0, "hold", edges, 16, 4, 0, 1, 0);

        // single re-pulse mid-sweep is ignored
        mode[0] = 0;
        run_sweep(0, 1'b0, 5, "repulse", edges);
        check_result(0, "repulse", edges, 16, 0, 0, 0, 1);

        // reset at e0+7 aborts the sweep
        mode[0] = 1;
        @(negedge clk) start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk) start[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midreset pre errors", errors[0], 1);
        check("midreset pre busy", 32'(busy[0]), 1);
        @(negedge clk) rst[0] = 1'b1;
        @(posedge clk);
        #1;
        check_reset(0, "midreset");
        @(negedge clk) rst[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset(0, "midreset idle");
        mode[0] = 0;
        run_sweep(0, 1'b0, 0, "post-reset", edges);
        check_result(0, "post-reset", edges, 16, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_check_ctrl.md
Name: vector_check_ctrl

Overview:
- Sequencer that drives every input combination into a combinational block under test and compares its output against a reference model.
- Counts mismatches, records the first failing vector, and reports pass/fail.
- Synthesisable replacement for the ad-hoc num/errors logic in our exhaustive self-checking benches; usable on-board with LEDs.
- Sits between a start source (button or bench), the DUT inputs, and the DUT plus reference-model outputs.

Parameters:
- N, 3, number of DUT input bits; 2^N vectors are swept.
- W, 1, width of DUT output and expected value.
- SETTLE, 1, wait cycles after each vector change before comparison; must be ≥ 1.
- ERRW, 32, width of the error counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level-sampled start request.
- vec  output  N  current test vector driven to DUT and reference model.
- dut_y  input  W  DUT output.
- exp_y  input  W  reference-model output.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until the next start.
- pass  output  1  valid while done; 1 iff errors == 0.
- errors  output  ERRW  mismatch count, saturating.
- first_err_vec  output  N  vector of the first mismatch; 0 if none.
- err_seen  output  1  at least one mismatch occurred this sweep.

Behaviour:
- Reset: state IDLE; vec=0, busy=0, done=0, pass=0, errors=0, first_err_vec=0, err_seen=0, wait counter=0. Reset overrides all other inputs, including mid-sweep.
- States: IDLE, WAIT, CHECK, DONE. Shared state enum is defined in the package.
- IDLE, start=1 at edge e0:
  - Next state WAIT; vec=0, cnt=0, busy=1.
  - Clear errors, err_seen, first_err_vec, done and pass.
- WAIT: cnt increments each edge. When cnt==SETTLE-1, go to CHECK and clear cnt.
- CHECK (exactly one cycle): mismatch = (dut_y != exp_y) over all W bits. At the leaving edge:
  - On mismatch, errors+1, saturating at 2^ERRW-1.
  - On mismatch with err_seen=0, set first_err_vec=vec and err_seen=1.
  - If vec == 2^N-1: go to DONE; busy=0, done=1, pass=(final errors==0), computed with this cycle's mismatch included.
  - Else: vec+1 and go to WAIT.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - Vector k is compared at edge e0+(k+1)(SETTLE+1).
  - done rises at edge e0+2^N·(SETTLE+1); for N=3, SETTLE=1 that is e0+16.
- DONE: outputs hold, and vec holds at 2^N-1. start=1 restarts exactly as from IDLE (all results cleared).
- start while WAIT or CHECK is ignored; no restart and no effect on results.
- vec changes only on edges leaving CHECK or on a start edge; it never glitches mid-vector.
- No wrap-around past 2^N-1. The counter must not overflow into 0 within a sweep.

Decomposition:
- Package vector_check_pkg:
  - state_t enum {IDLE, WAIT, CHECK, DONE}.
  - Helper constant function for the last vector (2^N-1).
- Sub-module vec_counter #(N): clear, enable, outputs q and last (q==2^N-1). It is reused for vec.
- The wait counter is inline.

Test Plan:
1. N=3, SETTLE=1; DUT is a correct model of y = a&~b | ~b&~c | ~a&b&c with {a,b,c}=vec, and exp_y is the same function. Pulse start → done at edge e0+16, errors=0, pass=1, err_seen=0, vec visited 0..7 in order.
2. dut_y stuck at 0, exp_y as in scenario 1 (ones at vectors 0, 3, 4, 5) → errors=4, first_err_vec=3'b000, err_seen=1, pass=0.
3. dut_y inverted only when vec==6 → errors=1, first_err_vec=3'b110, pass=0; all other compares clean.
4. start held high or re-pulsed at e0+5 during the sweep → ignored; done still at e0+16, errors unchanged from scenario 1.
5. reset asserted at e0+7 for one cycle → next edge all outputs at reset values and state IDLE. A new start then completes a full clean sweep (done 16 edges later).
6. SETTLE=3 with the fault from scenario 2 → done at e0+32, errors=4. Then start from DONE → errors clears to 0 on the start edge and the sweep repeats identically.
